// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: one bit per cycle,
// stalls EX while busy and pulses done with the result.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          op;
  logic                sa;
  logic                sb;
  logic [XLEN-1:0]     opnd;
  logic [2*XLEN-1:0]   prod;

  logic                sa_in;
  logic                sb_in;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                special;
  logic [XLEN-1:0]     spec_res;
  logic [XLEN:0]       msum;
  logic [XLEN:0]       trial;
  logic [2*XLEN-1:0]   step;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quot_s;
  logic [XLEN-1:0]     rem_s;
  logic [XLEN-1:0]     fix_res;

  // Launch decode: operand signs, magnitudes, special divides
  always_comb begin
    sa_in = rs1[XLEN-1] &
      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    sb_in = rs2[XLEN-1] &
      (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    mag_a = sa_in ? -rs1 : rs1;
    mag_b = sb_in ? -rs2 : rs2;
    special  = 1'b0;
    spec_res = '0;
    if (funct3[2] && rs2 == '0) begin
      special  = 1'b1;
      spec_res = funct3[1] ? rs1 : '1;
    end else if (funct3[2] && !funct3[0] &&
                 rs1 == {1'b1, {(XLEN-1){1'b0}}} &&
                 rs2 == '1) begin
      special  = 1'b1;
      spec_res = funct3[1] ? '0 : rs1;
    end
  end

  // One iteration: shift-add multiply or restoring divide
  always_comb begin
    msum  = {1'b0, prod[2*XLEN-1:XLEN]} +
            (prod[0] ? {1'b0, opnd} : '0);
    trial = prod[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    step  = '0;
    if (!op[2])
      step = {msum, prod[XLEN-1:1]};
    else if (!trial[XLEN])
      step = {trial[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    else
      step = {prod[2*XLEN-2:0], 1'b0};
  end

  // Sign fix-up and result selection
  always_comb begin
    prod_s = (sa ^ sb) ? -prod : prod;
    quot_s = (sa ^ sb) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_s  = sa ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    fix_res = rem_s;
    unique case (op)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_s;
      default:                fix_res = rem_s;
    endcase
  end

  assign stall = (state == IDLE && start && !flush) ||
                 state == CALC || state == FIX;

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op   <= funct3;
            sa   <= sa_in;
            sb   <= sb_in;
            cnt  <= '0;
            busy <= 1'b1;
            if (special) begin
              result <= spec_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              opnd  <= funct3[2] ? mag_b : mag_a;
              prod  <= {{XLEN{1'b0}},
                        funct3[2] ? mag_a : mag_b};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            prod <= step;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(XLEN-1))
              state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            result <= fix_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Hand-computed RV32M results and cycle latencies.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int ncmp = 0;
  int nerr = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Launch one op at edge N, report result, latency and stall profile
  task automatic run_op(
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          lat,
    output int          gaps,
    output logic        st_n,
    output logic        st_done
  );
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1 st_n = stall;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 99; gaps = 0; res = 'x; st_done = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; res = result; st_done = stall;
        break;
      end
      if (!stall) gaps++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; rs1 = '0; rs2 = '0;
    #12;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 ||
        stall !== 1'b0) begin
      nerr++;
      $display("FAIL reset: busy=%b done=%b result=%h stall=%b want 0 0 0 0",
               busy, done, result, stall);
    end
    start = 1'b1;
    #1;
    ncmp++;
    if (stall !== 1'b1) begin
      nerr++;
      $display("FAIL reset_stall_start: stall=%b want 1", stall);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat; int gaps; logic sn; logic sd;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFEB || lat != 34) begin
      nerr++;
      $display("FAIL mul: result=%h lat=%0d want FFFFFFEB 34", r, lat);
    end
    ncmp++;
    if (sn !== 1'b1 || gaps != 0 || sd !== 1'b0) begin
      nerr++;
      $display("FAIL mul_stall: stallN=%b gaps=%0d stall_done=%b want 1 0 0",
               sn, gaps, sd);
    end
    run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'h40000000 || lat != 34) begin
      nerr++;
      $display("FAIL mulh: result=%h lat=%0d want 40000000 34", r, lat);
    end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFFE || lat != 34) begin
      nerr++;
      $display("FAIL mulhu: result=%h lat=%0d want FFFFFFFE 34", r, lat);
    end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFFF || lat != 34) begin
      nerr++;
      $display("FAIL mulhsu: result=%h lat=%0d want FFFFFFFF 34", r, lat);
    end
  endtask

  task automatic test_div;
    logic [31:0] r; int lat; int gaps; logic sn; logic sd;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFFD || lat != 34) begin
      nerr++;
      $display("FAIL div: result=%h lat=%0d want FFFFFFFD 34", r, lat);
    end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFFF || lat != 34) begin
      nerr++;
      $display("FAIL rem: result=%h lat=%0d want FFFFFFFF 34", r, lat);
    end
    run_op(3'b101, 32'd100, 32'd7, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'd14 || lat != 34) begin
      nerr++;
      $display("FAIL divu: result=%h lat=%0d want 0000000E 34", r, lat);
    end
    run_op(3'b111, 32'd100, 32'd7, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'd2 || lat != 34) begin
      nerr++;
      $display("FAIL remu: result=%h lat=%0d want 00000002 34", r, lat);
    end
  endtask

  task automatic test_special;
    logic [31:0] r; int lat; int gaps; logic sn; logic sd;
    run_op(3'b100, 32'd5, 32'd0, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'hFFFFFFFF || lat != 1 || sn !== 1'b1 || sd !== 1'b0) begin
      nerr++;
      $display("FAIL div_by_zero: result=%h lat=%0d stallN=%b stall_done=%b want FFFFFFFF 1 1 0",
               r, lat, sn, sd);
    end
    run_op(3'b111, 32'd5, 32'd0, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'd5 || lat != 1) begin
      nerr++;
      $display("FAIL remu_by_zero: result=%h lat=%0d want 00000005 1", r, lat);
    end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'h80000000 || lat != 1) begin
      nerr++;
      $display("FAIL div_ovf: result=%h lat=%0d want 80000000 1", r, lat);
    end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'h0 || lat != 1) begin
      nerr++;
      $display("FAIL rem_ovf: result=%h lat=%0d want 00000000 1", r, lat);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int lat; int gaps; logic sn; logic sd;
    logic [31:0] prev; int seen;
    prev = result;
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev ||
        stall !== 1'b0) begin
      nerr++;
      $display("FAIL flush: busy=%b done=%b result=%h stall=%b want 0 0 %h 0",
               busy, done, result, stall, prev);
    end
    run_op(3'b101, 32'd100, 32'd9, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'd11 || lat != 34) begin
      nerr++;
      $display("FAIL after_flush: result=%h lat=%0d want 0000000B 34", r, lat);
    end
    // stray start pulses mid-operation must be ignored
    @(negedge clk);
    funct3 = 3'b111; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 99; seen = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k == 5 || k == 20) begin
        funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen++;
        if (seen == 1) begin
          lat = k; r = result;
        end
      end
    end
    start = 1'b0;
    ncmp++;
    if (r !== 32'd2 || lat != 34 || seen != 1) begin
      nerr++;
      $display("FAIL start_ignored: result=%h lat=%0d dones=%0d want 00000002 34 1",
               r, lat, seen);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] r; int lat; int gaps; logic sn; logic sd;
    @(negedge clk);
    funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 ||
        stall !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: busy=%b done=%b result=%h stall=%b want 0 0 0 0",
               busy, done, result, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b011, 32'd3, 32'd5, r, lat, gaps, sn, sd);
    ncmp++;
    if (r !== 32'h0 || lat != 34) begin
      nerr++;
      $display("FAIL mulhu_after_rst: result=%h lat=%0d want 00000000 34", r, lat);
    end
  endtask

  task automatic test_back_to_back;
    int l1; int l2; logic [31:0] r1; logic [31:0] r2;
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    l1 = 99; l2 = 99; r1 = 'x; r2 = 'x;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done) begin
        if (l1 == 99) begin
          l1 = k; r1 = result; rs2 = 32'd9;
        end else if (l2 == 99) begin
          l2 = k; r2 = result; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    ncmp++;
    if (r1 !== 32'd14 || l1 != 34) begin
      nerr++;
      $display("FAIL b2b_first: result=%h lat=%0d want 0000000E 34", r1, l1);
    end
    ncmp++;
    if (r2 !== 32'd11 || l2 != 69) begin
      nerr++;
      $display("FAIL b2b_second: result=%h lat=%0d want 0000000B 69", r2, l2);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
